// File: rtl/alu_seq.sv
// alu_seq: issue/writeback sequencer for an external 16-bit ALU; owns the register file and PSR.
// Optional feature macro: ALU_SEQ_IMM_EN (sign-extended 8-bit immediate replaces the Rsrc operand).
module alu_seq #(
    parameter int NREGS = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [4:0]   cmd_op,
    input  logic [3:0]   cmd_src,
    input  logic [3:0]   cmd_dst,
    input  logic         cmd_imm_sel,
    input  logic [7:0]   cmd_imm,
    output logic [W-1:0] alu_rsrc,
    output logic [W-1:0] alu_rdest,
    output logic [4:0]   alu_opcode,
    input  logic [W-1:0] alu_out,
    input  logic [4:0]   alu_flags,
    output logic         done,
    output logic         err,
    output logic [4:0]   psr,
    input  logic [3:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_CMP = 5'd2;
    localparam logic [4:0] OP_MAX = 5'd10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
    state_t state_q, state_d;

    logic [4:0]   op_q;
    logic [3:0]   src_q;
    logic [3:0]   dst_q;
    logic [W-1:0] rsrc_q;
    logic [W-1:0] rdest_q;
    logic [4:0]   opcode_q;
    logic [W-1:0] res_q;
    logic [4:0]   flags_q;
    logic [4:0]   psr_q;
    logic [W-1:0] rf_q [NREGS];
    logic [W-1:0] src_operand;
    logic         op_legal;
    logic         wb_en;

`ifdef ALU_SEQ_IMM_EN
    logic       imm_sel_q;
    logic [7:0] imm_q;
    assign src_operand = imm_sel_q ? {{(W-8){imm_q[7]}}, imm_q} : rf_q[src_q];
`else
    logic unused_imm;
    assign unused_imm  = ^{cmd_imm_sel, cmd_imm};
    assign src_operand = rf_q[src_q];
`endif

    assign op_legal = (op_q <= OP_MAX);
    assign wb_en    = op_legal && (op_q != OP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // done/err are masked by reset so an aborted writeback never signals completion.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                done    = !reset;
                err     = !reset && !op_legal;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            rsrc_q   <= '0;
            rdest_q  <= '0;
            opcode_q <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            psr_q    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
`ifdef ALU_SEQ_IMM_EN
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        src_q <= cmd_src;
                        dst_q <= cmd_dst;
`ifdef ALU_SEQ_IMM_EN
                        imm_sel_q <= cmd_imm_sel;
                        imm_q     <= cmd_imm;
`endif
                    end
                end
                S_READ: begin
                    rsrc_q   <= src_operand;
                    rdest_q  <= rf_q[dst_q];
                    opcode_q <= op_q;
                end
                S_EXEC: begin
                    res_q   <= alu_out;
                    flags_q <= alu_flags;
                end
                S_WB: begin
                    if (wb_en) begin
                        rf_q[dst_q] <= res_q;
                    end
                    // CMP leaves C and F alone: the ALU does not define them for compares.
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        psr_q <= flags_q;
                    end else if (op_q == OP_CMP) begin
                        psr_q[1] <= flags_q[1];
                        psr_q[3] <= flags_q[3];
                        psr_q[4] <= flags_q[4];
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_rsrc   = rsrc_q;
    assign alu_rdest  = rdest_q;
    assign alu_opcode = opcode_q;
    assign psr        = psr_q;
    assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU in the environment plus a register-file/PSR reference model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [3:0]  cmd_src;
    logic [3:0]  cmd_dst;
    logic        cmd_imm_sel;
    logic [7:0]  cmd_imm;
    logic [15:0] alu_rsrc;
    logic [15:0] alu_rdest;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_out;
    logic [4:0]  alu_flags;
    logic        done;
    logic        err;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
        .alu_rsrc(alu_rsrc), .alu_rdest(alu_rdest), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flags(alu_flags),
        .done(done), .err(err), .psr(psr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Returns {N,Z,F,L,C, result}; a = Rdest, b = Rsrc.
    function automatic logic [20:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] r;
        logic c, l, f, z, n;
        c = 1'b0; l = 1'b0; f = 1'b0; r = 16'h0000;
        case (op)
            5'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
                        f = (a[15] == b[15]) && (r[15] != a[15]); end
            5'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
                        f = (a[15] != b[15]) && (r[15] != a[15]); end
            5'd2: begin r = a - b; c = ~a[0]; f = b[0]; end
            5'd3: r = a & b;
            5'd4: r = a | b;
            5'd5: r = a ^ b;
            5'd6: r = ~a;
            5'd7: r = a << b[3:0];
            5'd8: r = a >> b[3:0];
            5'd9: r = 16'($signed(a) >>> b[3:0]);
            5'd10: begin p = 32'(a) * 32'(b); r = p[15:0]; end
            default: begin r = 16'hDEAD; c = 1'b1; l = 1'b1; f = 1'b1; end
        endcase
        z = (r == 16'h0000);
        n = r[15];
        if (op == 5'd2) begin
            z = (a == b);
            l = (a < b);
            n = ($signed(a) < $signed(b));
        end
        return {n, z, f, l, c, r};
    endfunction

    assign {alu_flags, alu_out} = alu_fn(alu_opcode, alu_rdest, alu_rsrc);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] ref_rf [16];
    logic [4:0]  ref_psr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0000;
        ref_psr = 5'h00;
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #0.1;
            check(tag, 32'(dbg_data), 32'(ref_rf[i]));
        end
    endtask

    task automatic do_cmd(input logic [4:0] op, input logic [3:0] src, input logic [3:0] dst,
                          input logic isel, input logic [7:0] imm);
        logic [15:0] a, b, r;
        logic [4:0]  fl;
        logic [20:0] fr;
        int          waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            step();
            waited++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        a = ref_rf[dst];
        b = ref_rf[src];
`ifdef ALU_SEQ_IMM_EN
        if (isel) b = {{8{imm[7]}}, imm};
`endif
        fr = alu_fn(op, a, b);
        {fl, r} = fr;
        cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_dst = dst;
        cmd_imm_sel = isel; cmd_imm = imm;
        step();                                   // READ
        check("ready_in_read", 32'(cmd_ready), 32'd0);
        check("done_in_read", 32'(done), 32'd0);
        // Commands presented while busy must be ignored.
        cmd_op = 5'($urandom); cmd_src = 4'($urandom); cmd_dst = 4'($urandom);
        cmd_imm_sel = 1'($urandom); cmd_imm = 8'($urandom);
        step();                                   // EXEC
        check("alu_rdest", 32'(alu_rdest), 32'(a));
        check("alu_rsrc", 32'(alu_rsrc), 32'(b));
        check("alu_opcode", 32'(alu_opcode), 32'(op));
        check("done_in_exec", 32'(done), 32'd0);
        step();                                   // WB
        check("done_in_wb", 32'(done), 32'd1);
        check("err_in_wb", 32'(err), 32'(op > 5'd10));
        check("ready_in_wb", 32'(cmd_ready), 32'd0);
        dbg_addr = dst;
        #1;
        check("dbg_old_in_wb", 32'(dbg_data), 32'(a));
        step();                                   // back in IDLE
        cmd_valid = 1'b0;
        check("ready_after_wb", 32'(cmd_ready), 32'd1);
        check("done_after_wb", 32'(done), 32'd0);
        check("err_after_wb", 32'(err), 32'd0);
        if (op <= 5'd10 && op != 5'd2) ref_rf[dst] = r;
        if (op == 5'd0 || op == 5'd1) begin
            ref_psr = fl;
        end else if (op == 5'd2) begin
            ref_psr[1] = fl[1];
            ref_psr[3] = fl[3];
            ref_psr[4] = fl[4];
        end
        dbg_addr = dst;
        #1;
        check("dbg_dst", 32'(dbg_data), 32'(ref_rf[dst]));
        check("psr", 32'(psr), 32'(ref_psr));
        dbg_addr = 4'($urandom);
        #1;
        check("dbg_rand", 32'(dbg_data), 32'(ref_rf[dbg_addr]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        int k;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_src = '0; cmd_dst = '0;
        cmd_imm_sel = 1'b0; cmd_imm = '0; dbg_addr = '0;
        model_reset();
        step(); step();
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsrc", 32'(alu_rsrc), 32'd0);
        check("rst_rdest", 32'(alu_rdest), 32'd0);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_psr", 32'(psr), 32'd0);
        check_all_regs("rst_regs");
        reset = 1'b0;
        step();

        do_cmd(5'd0, 4'd0, 4'd0, 1'b0, 8'h00);        // ADD r0,r0 -> Z
        check("add0_psr_z", 32'(psr[3]), 32'd1);
        do_cmd(5'd6, 4'd0, 4'd1, 1'b0, 8'h00);        // NOT r1 -> FFFF
        do_cmd(5'd1, 4'd1, 4'd2, 1'b0, 8'h00);        // r2 = 0 - FFFF = 1
        do_cmd(5'd0, 4'd2, 4'd1, 1'b0, 8'h00);        // r1 = FFFF + 1 -> 0, C, Z
        dbg_addr = 4'd1;
        #1;
        check("add_wrap_r1", 32'(dbg_data), 32'h0000);
        check("add_wrap_c", 32'(psr[0]), 32'd1);
        check("add_wrap_z", 32'(psr[3]), 32'd1);
        do_cmd(5'd2, 4'd2, 4'd2, 1'b0, 8'h00);        // CMP equal: Z, C kept
        check("cmp_c_kept", 32'(psr[0]), 32'd1);
        check("cmp_z", 32'(psr[3]), 32'd1);
        check("cmp_l", 32'(psr[1]), 32'd0);
        check("cmp_n", 32'(psr[4]), 32'd0);
        do_cmd(5'd15, 4'd2, 4'd1, 1'b0, 8'h00);       // illegal opcode
`ifdef ALU_SEQ_IMM_EN
        do_cmd(5'd0, 4'd0, 4'd7, 1'b1, 8'h07);        // r7 = 7
        do_cmd(5'd0, 4'd0, 4'd8, 1'b1, 8'h05);        // r8 = 5
        do_cmd(5'd10, 4'd7, 4'd8, 1'b0, 8'h00);       // r8 = 35
        dbg_addr = 4'd8;
        #1;
        check("mul_r8", 32'(dbg_data), 32'h0023);
`endif

        for (int i = 0; i < 250; i++) begin
            k  = int'($urandom_range(0, 13));
            op = (k <= 10) ? 5'(k) : 5'($urandom_range(11, 31));
            do_cmd(op, 4'($urandom), 4'($urandom), 1'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset during EXEC: no writeback, no done, back to IDLE.
        cmd_valid = 1'b1; cmd_op = 5'd6; cmd_src = 4'd0; cmd_dst = 4'd5;
        step();
        cmd_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("rst_exec_done", 32'(done), 32'd0);
        step();
        model_reset();
        check("rst_exec_ready", 32'(cmd_ready), 32'd1);
        check("rst_exec_psr", 32'(psr), 32'd0);
        check_all_regs("rst_exec_regs");
        reset = 1'b0;
        step();

        // Reset during WB: done/err masked, write dropped.
        cmd_valid = 1'b1; cmd_op = 5'd6; cmd_src = 4'd0; cmd_dst = 4'd3;
        step();
        cmd_valid = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("rst_wb_done", 32'(done), 32'd0);
        step();
        reset = 1'b0;
        dbg_addr = 4'd3;
        #1;
        check("rst_wb_r3", 32'(dbg_data), 32'h0000);
        check("rst_wb_ready", 32'(cmd_ready), 32'd1);
        step();

        do_cmd(5'd6, 4'd0, 4'd4, 1'b0, 8'h00);
        do_cmd(5'd1, 4'd4, 4'd6, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
